// File: rtl/led_pattern_engine.sv
// LED pattern engine: debounced push-button control of a run-time adjustable blink
// divider, driving four auto-cycled (or held) display modes on the green/red LED bars.
`timescale 1ns/1ps
module led_pattern_engine #(
    parameter int unsigned CNT_W            = 32,
    parameter int unsigned N_GREEN          = 8,
    parameter int unsigned N_RED            = 10,
    parameter int unsigned TICK_INIT        = 25000000,
    parameter int unsigned TICK_STEP        = 12500000,
    parameter int unsigned TICK_MIN         = 12500000,
    parameter int unsigned TICK_MAX         = 250000000,
    parameter int unsigned TOGGLES_PER_MODE = 6,
    parameter int unsigned DEB_CYCLES       = 500000
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic [3:0]         KEY,
    output logic [N_GREEN-1:0] LEDG,
    output logic [N_RED-1:0]   LEDR,
    output logic [1:0]         MODE,
    output logic               HOLD
);

    localparam int unsigned N_LED = N_GREEN + N_RED;
    localparam int unsigned POS_W = $clog2(N_LED);
    localparam int unsigned TOG_W = $clog2(TOGGLES_PER_MODE + 1);
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

    localparam logic [CNT_W-1:0] TickInit    = CNT_W'(TICK_INIT);
    localparam logic [CNT_W-1:0] TickStep    = CNT_W'(TICK_STEP);
    localparam logic [CNT_W-1:0] TickMin     = CNT_W'(TICK_MIN);
    localparam logic [CNT_W-1:0] TickMax     = CNT_W'(TICK_MAX);
    // Clamp thresholds precomputed so the period arithmetic can never wrap
    localparam logic [CNT_W-1:0] DecFloor    = CNT_W'(TICK_MIN + TICK_STEP);
    localparam logic [CNT_W-1:0] IncCeil     = CNT_W'(TICK_MAX - TICK_STEP);
    localparam logic [POS_W-1:0] PosLast     = POS_W'(N_LED - 1);
    localparam logic [TOG_W-1:0] TogLast     = TOG_W'(TOGGLES_PER_MODE - 1);
    localparam logic [DEB_W-1:0] DebLast     = DEB_W'(DEB_CYCLES - 1);

    // Key path state
    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       deb_q, deb_d;
    logic [3:0]       deb_dly_q;
    logic [DEB_W-1:0] deb_cnt_q [4];
    logic [DEB_W-1:0] deb_cnt_d [4];
    logic [3:0]       press;

    // Core state
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              phase_q, phase_d;
    logic [1:0]        mode_q, mode_d;
    logic [TOG_W-1:0]  tog_q, tog_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              hold_q, hold_d;
    logic              tick;

    // Registered outputs
    logic [N_GREEN-1:0] ledg_q, ledg_d;
    logic [N_RED-1:0]   ledr_q, ledr_d;
    logic [1:0]         mode_o_q;
    logic               hold_o_q;
    logic [N_LED-1:0]   chase;

    // Debounce: accept a new level once it has differed for DEB_CYCLES consecutive samples
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_d[i]     = deb_q[i];
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DebLast) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
        // Active-low keys: a press is a debounced 1->0 edge
        press = deb_dly_q & ~deb_q;
    end

    // Key synchroniser, debounce and edge-detect registers
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            deb_q     <= '1;
            deb_dly_q <= '1;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= KEY;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // Divider, period adjust, mode sequencing and output decode
    always_comb begin
        tick  = (cnt_q >= period_q);
        cnt_d = tick ? '0 : cnt_q + 1'b1;

        period_d = period_q;
        if (press[2]) begin
            period_d = TickInit;
        end else if (press[1]) begin
            period_d = (period_q < DecFloor) ? TickMin : period_q - TickStep;
        end else if (press[0]) begin
            period_d = (period_q > IncCeil) ? TickMax : period_q + TickStep;
        end

        hold_d  = hold_q ^ press[3];
        phase_d = phase_q;
        mode_d  = mode_q;
        tog_d   = tog_q;
        pos_d   = pos_q;
        if (tick) begin
            phase_d = ~phase_q;
            if (mode_q == 2'd3) begin
                pos_d = (pos_q == PosLast) ? '0 : pos_q + 1'b1;
            end
            if (hold_q) begin
                tog_d = '0;
            end else if (tog_q == TogLast) begin
                tog_d   = '0;
                mode_d  = mode_q + 1'b1;
                phase_d = 1'b0;
                if (mode_q == 2'd2) begin
                    pos_d = '0;
                end
            end else begin
                tog_d = tog_q + 1'b1;
            end
        end

        chase = N_LED'(1) << pos_q;
        unique case (mode_q)
            2'd0: begin
                ledg_d = {N_GREEN{phase_q}};
                ledr_d = '0;
            end
            2'd1: begin
                ledg_d = '0;
                ledr_d = {N_RED{phase_q}};
            end
            2'd2: begin
                ledg_d = {N_GREEN{phase_q}};
                ledr_d = {N_RED{phase_q}};
            end
            2'd3: begin
                ledg_d = chase[N_GREEN-1:0];
                ledr_d = chase[N_LED-1:N_GREEN];
            end
        endcase
    end

    // Core state and registered outputs
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q    <= '0;
            period_q <= TickInit;
            phase_q  <= 1'b0;
            mode_q   <= 2'd0;
            tog_q    <= '0;
            pos_q    <= '0;
            hold_q   <= 1'b0;
            ledg_q   <= '0;
            ledr_q   <= '0;
            mode_o_q <= 2'd0;
            hold_o_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            phase_q  <= phase_d;
            mode_q   <= mode_d;
            tog_q    <= tog_d;
            pos_q    <= pos_d;
            hold_q   <= hold_d;
            ledg_q   <= ledg_d;
            ledr_q   <= ledr_d;
            mode_o_q <= mode_q;
            hold_o_q <= hold_q;
        end
    end

    assign LEDG = ledg_q;
    assign LEDR = ledr_q;
    assign MODE = mode_o_q;
    assign HOLD = hold_o_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine with small divider/debounce parameters.
// Every tick changes {LEDR,LEDG}, so tick intervals are measured from output changes.
`timescale 1ns/1ps
module tb_led_pattern_engine;

    localparam int unsigned NG  = 8;
    localparam int unsigned NR  = 10;
    localparam int unsigned TI  = 9;
    localparam int unsigned TS  = 4;
    localparam int unsigned TMN = 4;
    localparam int unsigned TMX = 21;
    localparam int unsigned TPM = 6;
    localparam int unsigned DEB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    key;
    logic [NG-1:0] ledg;
    logic [NR-1:0] ledr;
    logic [1:0]    mode;
    logic          hold;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    typedef struct {
        int unsigned interval;
        bit          chk_led;
        logic [7:0]  g;
        logic [9:0]  r;
        logic [1:0]  m;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    led_pattern_engine #(
        .CNT_W            (32),
        .N_GREEN          (NG),
        .N_RED            (NR),
        .TICK_INIT        (TI),
        .TICK_STEP        (TS),
        .TICK_MIN         (TMN),
        .TICK_MAX         (TMX),
        .TOGGLES_PER_MODE (TPM),
        .DEB_CYCLES       (DEB)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .KEY      (key),
        .LEDG     (ledg),
        .LEDR     (ledr),
        .MODE     (mode),
        .HOLD     (hold)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Cycles until {LEDR,LEDG} changes (bounded)
    task automatic wait_change(output int unsigned n);
        logic [17:0] snap;
        snap = {ledr, ledg};
        n = 0;
        do begin
            cyc();
            n++;
        end while ({ledr, ledg} === snap && n < 200);
    endtask

    task automatic push(input int unsigned iv, input bit c, input logic [7:0] g,
                        input logic [9:0] r, input logic [1:0] m);
        sb.push_back('{interval: iv, chk_led: c, g: g, r: r, m: m});
    endtask

    // Pop one expectation per observed tick and compare
    task automatic drain(input string tag);
        exp_t e;
        int unsigned n;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_change(n);
            check({tag, " interval"}, n, e.interval);
            if (e.chk_led) begin
                check({tag, " LEDG"}, ledg, e.g);
                check({tag, " LEDR"}, ledr, e.r);
                check({tag, " MODE"}, mode, e.m);
            end
        end
    endtask

    task automatic press(input logic [3:0] mask, input int unsigned low);
        key = 4'hF & ~mask;
        repeat (low) cyc();
        key = 4'hF;
        repeat (DEB + 6) cyc();
    endtask

    // Resync on a tick, then expect a steady interval of per+1
    task automatic measure(input int unsigned per, input string tag);
        int unsigned n;
        wait_change(n);
        push(per + 1, 1'b0, 8'h00, 10'h000, 2'd0);
        drain(tag);
    endtask

    task automatic wait_mode(input logic [1:0] m, output bit ok);
        int unsigned n;
        n = 0;
        while (mode !== m && n < 400) begin
            cyc();
            n++;
        end
        ok = (mode === m);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        bit          ok;
        logic [17:0] ch;
        logic [17:0] snap;
        int unsigned mm, kk;
        logic [7:0]  g;
        logic [9:0]  r;

        rst_n = 1'b0;
        key   = 4'hF;
        repeat (3) cyc();
        check("reset LEDG", ledg, 0);
        check("reset LEDR", ledr, 0);
        check("reset MODE", mode, 0);
        check("reset HOLD", hold, 0);

        // Auto-cycle walk through all four modes; first output change lands TI+2 cycles
        // after release (tick edge plus one cycle of output register)
        rst_n = 1'b1;
        for (int t = 1; t <= 25; t++) begin
            mm = (t / TPM) % 4;
            kk = t % TPM;
            ch = 18'(1) << kk;
            g  = 8'h00;
            r  = 10'h000;
            case (mm)
                0: g = (kk % 2 == 1) ? 8'hFF : 8'h00;
                1: r = (kk % 2 == 1) ? 10'h3FF : 10'h000;
                2: begin
                    g = (kk % 2 == 1) ? 8'hFF : 8'h00;
                    r = (kk % 2 == 1) ? 10'h3FF : 10'h000;
                end
                default: begin
                    g = ch[7:0];
                    r = ch[17:8];
                end
            endcase
            push((t == 1) ? TI + 2 : TI + 1, 1'b1, g, r, mm[1:0]);
        end
        drain("walk");

        // Period clamps
        press(4'b0001, 12); measure(13, "slower1");
        press(4'b0001, 12); measure(17, "slower2");
        press(4'b0001, 12); measure(21, "slower3");
        press(4'b0001, 12); measure(21, "slower4");
        press(4'b0001, 12); measure(21, "slower5");
        press(4'b0100, 12); measure(9, "init");
        press(4'b0010, 12); measure(5, "faster1");
        press(4'b0010, 12); measure(4, "faster2");
        press(4'b0010, 12); measure(4, "faster3");

        // Debounce
        press(4'b0001, 3);  measure(4, "glitch");
        press(4'b0001, 20); measure(8, "long press");
        press(4'b0101, 12); measure(9, "key0+key2");

        // Chase with hold
        wait_mode(2'd3, ok);
        check("reach mode3", ok, 1);
        press(4'b1000, 12);
        check("hold set HOLD", hold, 1);
        check("hold set MODE", mode, 3);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            wait_change(n);
            ok = (ledg === 8'h01);
        end
        check("chase sync", ok, 1);
        for (int p = 1; p <= 19; p++) begin
            ch = 18'(1) << (p % 18);
            push(TI + 1, 1'b1, ch[7:0], ch[17:8], 2'd3);
        end
        drain("chase");
        check("chase HOLD", hold, 1);
        press(4'b1000, 12);
        check("resume HOLD", hold, 0);
        wait_mode(2'd0, ok);
        check("resume reach mode0", ok, 1);

        // Mid-count shrink: period 21, KEY[2] lands when cnt=15
        press(4'b0001, 12);
        press(4'b0001, 12);
        press(4'b0001, 12);
        measure(21, "pre-shrink");
        wait_change(n);
        snap = {ledr, ledg};
        n = 0;
        do begin
            cyc();
            n++;
            if (n == 7) key = 4'b1011;
        end while ({ledr, ledg} === snap && n < 200);
        check("shrink first tick", n, 16);
        push(TI + 1, 1'b0, 8'h00, 10'h000, 2'd0);
        drain("post-shrink");
        key = 4'hF;
        repeat (DEB + 6) cyc();

        // Asynchronous reset mid-chase with hold active
        wait_mode(2'd3, ok);
        check("reach mode3 again", ok, 1);
        press(4'b1000, 12);
        check("pre-reset HOLD", hold, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async reset LEDG", ledg, 0);
        check("async reset LEDR", ledr, 0);
        check("async reset MODE", mode, 0);
        check("async reset HOLD", hold, 0);
        cyc();
        rst_n = 1'b1;
        wait_change(n);
        check("post-reset first tick", n, TI + 2);
        check("post-reset LEDG", ledg, 8'hFF);
        check("post-reset MODE", mode, 0);
        check("post-reset HOLD", hold, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
